// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

    // Which requester owns the read data returning from memory this cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    // RISC-V canonical NOP (addi x0, x0, 0), shown to fetch out of reset.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Memory read latency in cycles; the return path assumes exactly one.
    localparam int MEM_RD_LAT = 1;

endpackage

// File: rtl/mem_port_arbiter_rdata_steer.sv
// Read-data return path: tracks who issued last cycle's read and steers mem data back.
// Latency: data appears one cycle after the grant; fetch data held stable otherwise.
// Backpressure: none; the owner register follows the grant every cycle.
// Ports: clk/reset_n, fetch_gnt/load_gnt (this cycle's grants), mem_rdata (memory
//        read data), if_rdata/d_rdata/d_rvalid (per-requester return outputs).
module arb_rdata_steer
    import mem_port_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_gnt,
    input  logic        load_gnt,
    input  logic [31:0] mem_rdata,
    output logic [31:0] if_rdata,
    output logic [31:0] d_rdata,
    output logic        d_rvalid
);

    owner_e      rd_owner;
    logic [31:0] hold_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_owner <= OWN_NONE;
            hold_q   <= NOP_INSTR;
        end else begin
            if (fetch_gnt) begin
                rd_owner <= OWN_IF;
            end else if (load_gnt) begin
                rd_owner <= OWN_D;
            end else begin
                rd_owner <= OWN_NONE;
            end
            // Capture every returned instruction so it survives any later stall.
            if (rd_owner == OWN_IF) begin
                hold_q <= mem_rdata;
            end
        end
    end

    // Reset is synchronous, so rd_owner can still hold a pre-reset grant during
    // the first reset cycle; gate the outputs so nothing from it escapes.
    assign d_rvalid = reset_n & (rd_owner == OWN_D);
    assign d_rdata  = d_rvalid ? mem_rdata : 32'd0;
    assign if_rdata = !reset_n               ? NOP_INSTR :
                      (rd_owner == OWN_IF)   ? mem_rdata : hold_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and load/store.
// Latency: grant is combinational; read data returns one cycle after the grant.
// Backpressure: data wins; a denied fetch raises stall_if_o. Optional fairness guard
//               under macro ARB_STARVE_GUARD_EN forces a fetch after STREAK_MAX data grants.
// Ports: if_* fetch port, d_* load/store port, mem_* memory port, stall_if_o fetch stall.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int STREAK_MAX = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [31:0]       if_rdata_o,
    output logic              stall_if_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [31:0]       d_wdata_i,
    input  logic [3:0]        d_wstrb_i,
    output logic              d_gnt_o,
    output logic [31:0]       d_rdata_o,
    output logic              d_rvalid_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [3:0]        mem_wstrb_o,
    input  logic [31:0]       mem_rdata_i
);

    logic data_gnt;
    logic fetch_gnt;
    logic force_fetch;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STREAK_MAX + 1);

    logic [CNT_W-1:0] streak_q;

    // After STREAK_MAX data grants in a row with fetch waiting, hand one slot to fetch.
    assign force_fetch = d_req_i & if_req_i & (streak_q == CNT_W'(STREAK_MAX));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            streak_q <= '0;
        end else if (!if_req_i || fetch_gnt) begin
            streak_q <= '0;
        end else if (data_gnt) begin
            streak_q <= streak_q + CNT_W'(1);
        end
    end
`else
    logic unused_streak;
    assign unused_streak = (STREAK_MAX == 0);
    assign force_fetch   = 1'b0;
`endif

    logic unused_lat;
    assign unused_lat = (MEM_RD_LAT != 1);

    // Grants are masked during reset so the memory sees no access.
    assign data_gnt   = reset_n & d_req_i & ~force_fetch;
    assign fetch_gnt  = reset_n & if_req_i & ~data_gnt;
    assign stall_if_o = reset_n & if_req_i & ~fetch_gnt;
    assign d_gnt_o    = data_gnt;

    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_wstrb_o = '0;
        if (data_gnt) begin
            mem_en_o    = 1'b1;
            mem_we_o    = d_we_i;
            mem_addr_o  = d_addr_i;
            mem_wdata_o = d_wdata_i;
            mem_wstrb_o = d_wstrb_i;
        end else if (fetch_gnt) begin
            mem_en_o    = 1'b1;
            mem_addr_o  = if_addr_i;
        end
    end

    arb_rdata_steer u_steer (
        .clk       (clk),
        .reset_n   (reset_n),
        .fetch_gnt (fetch_gnt),
        .load_gnt  (data_gnt & ~d_we_i),
        .mem_rdata (mem_rdata_i),
        .if_rdata  (if_rdata_o),
        .d_rdata   (d_rdata_o),
        .d_rvalid  (d_rvalid_o)
    );

endmodule
